// File: rtl/dram_defs_pkg.sv
// Shared definitions for the dRam streaming front end and its address path.
package dram_defs;

  localparam int ADDR_W = 19;
  localparam int DATA_W = 8;

  // dRam write-enable encodings; only these two values are ever driven.
  localparam logic [1:0] MW_IDLE  = 2'b00;
  localparam logic [1:0] MW_WRITE = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_DUMP_RD  = 3'd2,
    ST_DUMP_CAP = 3'd3,
    ST_DUMP_OUT = 3'd4,
    ST_DONE     = 3'd5
  } state_t;

endpackage

// File: rtl/dram_addr_gen.sv
// Address/count generator: loads a base and a length, then steps the
// address and the transferred-byte count together. The address wraps
// modulo 2**ADDR_W. The last flag marks the final byte of the region.
module dram_addr_gen
  import dram_defs::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] length,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] len;

  // Capture the region on load, otherwise advance one byte per step.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr <= '0;
      cnt  <= '0;
      len  <= '0;
    end else if (load) begin
      addr <= base;
      cnt  <= '0;
      len  <= length;
    end else if (step) begin
      addr <= addr + ADDR_W'(1);
      cnt  <= cnt + ADDR_W'(1);
    end
  end

  assign last = ((cnt + ADDR_W'(1)) == len);

endmodule

// File: rtl/dram_stream_ctrl.sv
// Byte-stream front end for dRam. LOAD writes an incoming stream into
// dRam; DUMP reads a region back out as a stream. Owns dAddr, d_in and
// MEM_WRITE. The dRam read has one cycle of latency, so a DUMP byte takes
// a read cycle, a capture cycle and at least one output cycle.
module dram_stream_ctrl
  import dram_defs::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] length,
  output logic              busy,
  output logic              done,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] dAddr,
  output logic [DATA_W-1:0] d_in,
  output logic [1:0]        MEM_WRITE,
  input  logic [DATA_W-1:0] d_out
);

  state_t            state;
  state_t            next_state;
  logic              ag_load;
  logic              ag_step;
  logic              last;
  logic [ADDR_W-1:0] addr;

  dram_addr_gen u_addr_gen (
    .clk    (clk),
    .rst    (rst),
    .load   (ag_load),
    .step   (ag_step),
    .base   (base_addr),
    .length (length),
    .addr   (addr),
    .last   (last)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  // Next-state logic; start is only looked at in IDLE.
  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          if (length == '0) next_state = ST_DONE;
          else if (mode)    next_state = ST_DUMP_RD;
          else              next_state = ST_LOAD;
        end
      end
      ST_LOAD:     if (in_valid && last) next_state = ST_DONE;
      ST_DUMP_RD:  next_state = ST_DUMP_CAP;
      ST_DUMP_CAP: next_state = ST_DUMP_OUT;
      ST_DUMP_OUT: if (out_ready) next_state = last ? ST_DONE : ST_DUMP_RD;
      ST_DONE:     next_state = ST_IDLE;
      default:     next_state = ST_IDLE;
    endcase
  end

  // Status flags and address-generator controls decoded from the state.
  always_comb begin
    busy     = (state != ST_IDLE);
    done     = (state == ST_DONE);
    in_ready = (state == ST_LOAD);
    ag_load  = (state == ST_IDLE) && start;
    ag_step  = ((state == ST_LOAD) && in_valid) ||
               ((state == ST_DUMP_OUT) && out_ready);
  end

  // Registered dRam port and output stream; dAddr is set on entry to
  // DUMP_RD so the read data is on d_out during DUMP_CAP.
  always_ff @(posedge clk) begin
    if (rst) begin
      dAddr     <= '0;
      d_in      <= '0;
      MEM_WRITE <= MW_IDLE;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      MEM_WRITE <= MW_IDLE;
      unique case (state)
        ST_IDLE: begin
          if (start && mode && (length != '0)) dAddr <= base_addr;
        end
        ST_LOAD: begin
          if (in_valid) begin
            dAddr     <= addr;
            d_in      <= in_data;
            MEM_WRITE <= MW_WRITE;
          end
        end
        ST_DUMP_CAP: begin
          out_data  <= d_out;
          out_valid <= 1'b1;
        end
        ST_DUMP_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (!last) dAddr <= addr + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_stream_ctrl.sv
// Directed bench for dram_stream_ctrl together with a behavioural dRam.
module tb_dram_stream_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        mode;
  logic [18:0] base_addr;
  logic [18:0] length;
  logic        busy;
  logic        done;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [18:0] dAddr;
  logic [7:0]  d_in;
  logic [1:0]  MEM_WRITE;
  logic [7:0]  d_out;

  logic [7:0]  dram [0:524287];

  int tests_run    = 0;
  int tests_failed = 0;

  dram_stream_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .base_addr (base_addr),
    .length    (length),
    .busy      (busy),
    .done      (done),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dAddr     (dAddr),
    .d_in      (d_in),
    .MEM_WRITE (MEM_WRITE),
    .d_out     (d_out)
  );

  always #5 clk = ~clk;

  // Behavioural dRam: write on MEM_WRITE=10, read data one cycle after address.
  always @(posedge clk) begin
    if (MEM_WRITE == 2'b10) dram[dAddr] <= d_in;
    d_out <= dram[dAddr];
  end

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; mode = 1'b0; base_addr = '0; length = '0;
    in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({busy, done, in_ready, out_valid} !== 4'b0000) begin
      tests_failed++;
      $display("[TB] FAIL reset_flags got %b exp 0000", {busy, done, in_ready, out_valid});
    end
    tests_run++;
    if ({out_data, dAddr, d_in, MEM_WRITE} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_regs out_data=%h dAddr=%h d_in=%h mw=%b exp all 0",
               out_data, dAddr, d_in, MEM_WRITE);
    end
    rst = 1'b0;
  endtask

  task automatic test_load();
    logic [1:0]  exp_mw;
    @(negedge clk);
    start = 1'b1; mode = 1'b0; base_addr = 19'd4; length = 19'd3;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      start  = 1'b0;
      exp_mw = (c >= 1 && c <= 3) ? 2'b10 : 2'b00;
      tests_run++;
      if (MEM_WRITE !== exp_mw) begin
        tests_failed++;
        $display("[TB] FAIL load_mw c=%0d got %b exp %b", c, MEM_WRITE, exp_mw);
      end
      if (c >= 1 && c <= 3) begin
        tests_run++;
        if (dAddr !== 19'(3 + c) || d_in !== 8'(19 + c)) begin
          tests_failed++;
          $display("[TB] FAIL load_write c=%0d got addr %0d data %0d exp addr %0d data %0d",
                   c, dAddr, d_in, 3 + c, 19 + c);
        end
      end
      tests_run++;
      if (done !== (c == 3) || in_ready !== (c < 3)) begin
        tests_failed++;
        $display("[TB] FAIL load_flags c=%0d got done %b in_ready %b exp %b %b",
                 c, done, in_ready, c == 3, c < 3);
      end
      in_valid = (c < 3);
      in_data  = 8'(20 + c);
    end
    in_valid = 1'b0;
    tests_run++;
    if (dram[4] !== 8'd20 || dram[5] !== 8'd21 || dram[6] !== 8'd22) begin
      tests_failed++;
      $display("[TB] FAIL load_mem got %0d %0d %0d exp 20 21 22", dram[4], dram[5], dram[6]);
    end
  endtask

  task automatic test_dump_backpressure();
    logic [7:0] exp_d [3];
    int idx;
    bit ph;
    exp_d = '{8'd20, 8'd21, 8'd22};
    idx = 0;
    ph  = 1'b1;
    @(negedge clk);
    start = 1'b1; mode = 1'b1; base_addr = 19'd4; length = 19'd3; out_ready = 1'b0;
    for (int c = 0; c < 30 && idx < 3; c++) begin
      @(negedge clk);
      start = 1'b0;
      tests_run++;
      if (done !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL dump_early_done c=%0d got %b exp 0", c, done);
      end
      if (out_valid === 1'b1) begin
        tests_run++;
        if (out_data !== exp_d[idx]) begin
          tests_failed++;
          $display("[TB] FAIL dump_data idx=%0d got %0d exp %0d", idx, out_data, exp_d[idx]);
        end
        out_ready = ph;
        if (ph) idx++;
        ph = ~ph;
      end else begin
        out_ready = 1'b1;
      end
    end
    tests_run++;
    if (idx != 3) begin
      tests_failed++;
      $display("[TB] FAIL dump_count got %0d exp 3", idx);
    end
    @(negedge clk);
    out_ready = 1'b0;
    tests_run++;
    if (done !== 1'b1 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL dump_done got done %b out_valid %b exp 1 0", done, out_valid);
    end
    @(negedge clk);
    tests_run++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL dump_idle got done %b busy %b exp 0 0", done, busy);
    end
  endtask

  task automatic test_zero_length();
    for (int m = 0; m < 2; m++) begin
      @(negedge clk);
      start = 1'b1; mode = m[0]; base_addr = 19'd9; length = 19'd0;
      @(negedge clk);
      start = 1'b0;
      tests_run++;
      if (done !== 1'b1 || MEM_WRITE !== 2'b00 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL zero_len_done mode=%0d got done %b mw %b in_ready %b out_valid %b exp 1 00 0 0",
                 m, done, MEM_WRITE, in_ready, out_valid);
      end
      @(negedge clk);
      tests_run++;
      if (done !== 1'b0 || busy !== 1'b0 || MEM_WRITE !== 2'b00) begin
        tests_failed++;
        $display("[TB] FAIL zero_len_after mode=%0d got done %b busy %b mw %b exp 0 0 00",
                 m, done, busy, MEM_WRITE);
      end
    end
  endtask

  task automatic test_wrap();
    logic [18:0] exp_a [2];
    logic [7:0]  exp_d [2];
    int idx;
    exp_a = '{19'h7FFFF, 19'h00000};
    exp_d = '{8'hAA, 8'hBB};
    @(negedge clk);
    start = 1'b1; mode = 1'b0; base_addr = 19'h7FFFF; length = 19'd2;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 1 || c == 2) begin
        tests_run++;
        if (MEM_WRITE !== 2'b10 || dAddr !== exp_a[c-1] || d_in !== exp_d[c-1]) begin
          tests_failed++;
          $display("[TB] FAIL wrap_write c=%0d got mw %b addr %h data %h exp 10 %h %h",
                   c, MEM_WRITE, dAddr, d_in, exp_a[c-1], exp_d[c-1]);
        end
      end
      in_valid = (c < 2);
      in_data  = (c < 2) ? exp_d[c] : 8'h00;
    end
    in_valid = 1'b0;
    idx = 0;
    @(negedge clk);
    start = 1'b1; mode = 1'b1; base_addr = 19'h7FFFF; length = 19'd2; out_ready = 1'b1;
    for (int c = 0; c < 20 && idx < 2; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (out_valid === 1'b1) begin
        tests_run++;
        if (out_data !== exp_d[idx]) begin
          tests_failed++;
          $display("[TB] FAIL wrap_dump idx=%0d got %h exp %h", idx, out_data, exp_d[idx]);
        end
        idx++;
      end
    end
    @(negedge clk);
    out_ready = 1'b0;
    tests_run++;
    if (idx != 2 || done !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL wrap_dump_end got count %0d done %b exp 2 1", idx, done);
    end
  endtask

  task automatic test_reset_mid_load();
    logic [7:0] old1;
    @(negedge clk);
    old1  = dram[1];
    start = 1'b1; mode = 1'b0; base_addr = 19'd0; length = 19'd4;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; in_data = 8'h11;
    @(negedge clk);
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL rst_mid_ready got %b exp 1", in_ready);
    end
    in_data = 8'h55; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    tests_run++;
    if (MEM_WRITE !== 2'b00 || busy !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL rst_mid_state got mw %b busy %b in_ready %b done %b exp 00 0 0 0",
               MEM_WRITE, busy, in_ready, done);
    end
    repeat (2) @(negedge clk);
    tests_run++;
    if (dram[1] !== old1 || dram[0] !== 8'h11 || MEM_WRITE !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL rst_mid_mem got dram1 %h dram0 %h mw %b exp %h 11 00",
               dram[1], dram[0], MEM_WRITE, old1);
    end
  endtask

  task automatic test_ignored_start();
    int done_cnt;
    logic [7:0] old100;
    done_cnt = 0;
    old100   = dram[100];
    @(negedge clk);
    start = 1'b1; mode = 1'b0; base_addr = 19'd16; length = 19'd3;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
      tests_run++;
      if (MEM_WRITE !== ((c == 1 || c == 4 || c == 7) ? 2'b10 : 2'b00)) begin
        tests_failed++;
        $display("[TB] FAIL stall_mw c=%0d got %b", c, MEM_WRITE);
      end
      if (c == 1 || c == 4 || c == 7) begin
        tests_run++;
        if (dAddr !== 19'(16 + c / 3) || d_in !== 8'(8'h31 + c / 3)) begin
          tests_failed++;
          $display("[TB] FAIL stall_write c=%0d got addr %0d data %h exp %0d %h",
                   c, dAddr, d_in, 16 + c / 3, 8'(8'h31 + c / 3));
        end
      end
      tests_run++;
      if (in_ready !== (c < 7) || busy !== (c < 8)) begin
        tests_failed++;
        $display("[TB] FAIL stall_flags c=%0d got in_ready %b busy %b exp %b %b",
                 c, in_ready, busy, c < 7, c < 8);
      end
      in_valid = (c == 0 || c == 3 || c == 6);
      in_data  = 8'(8'h31 + c / 3);
      start    = (c == 2 || c == 7);
      mode     = (c == 2 || c == 7);
      base_addr = (c == 2 || c == 7) ? 19'd100 : 19'd16;
      length    = (c == 2 || c == 7) ? 19'd5 : 19'd3;
    end
    tests_run++;
    if (done_cnt != 1) begin
      tests_failed++;
      $display("[TB] FAIL stall_done_count got %0d exp 1", done_cnt);
    end
    tests_run++;
    if (dram[16] !== 8'h31 || dram[17] !== 8'h32 || dram[18] !== 8'h33 || dram[100] !== old100) begin
      tests_failed++;
      $display("[TB] FAIL stall_mem got %h %h %h %h exp 31 32 33 %h",
               dram[16], dram[17], dram[18], dram[100], old100);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_dump_backpressure();
    test_zero_length();
    test_wrap();
    test_reset_mid_load();
    test_ignored_start();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
